// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the mux8 round-robin arbiter.
package mux8_arb_pkg;

    localparam int NUM_REQ          = 8;
    localparam int SEL_W            = 3;
    localparam int DEFAULT_MAX_HOLD = 16;

    // Encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
// The lock signal exists only when MUX8_ARB_LOCK_EN is defined.
interface mux8_rr_arbiter_if;
    import mux8_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
`ifdef MUX8_ARB_LOCK_EN
    logic               lock;
`endif
    logic [NUM_REQ-1:0] grant;
    logic [SEL_W-1:0]   sel;
    logic               busy;
    arb_state_t         dbg_state;

    // req (and lock) are levels held by the requester; grant/sel/busy are
    // registered and change only on clk edges or on asynchronous reset.
`ifdef MUX8_ARB_LOCK_EN
    modport master (output req, lock, input grant, sel, busy, dbg_state);
    modport slave  (input req, lock, output grant, sel, busy, dbg_state);
`else
    modport master (output req, input grant, sel, busy, dbg_state);
    modport slave  (input req, output grant, sel, busy, dbg_state);
`endif

endinterface

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Combinational round-robin pick: first requester at or above ptr, modulo 8.
module rr_pick8
    import mux8_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   pick,
    output logic               any
);

    logic [NUM_REQ-1:0] w_rot;
    logic [SEL_W-1:0]   w_idx;

    // Rotating right by ptr puts requester ptr at bit 0 of w_rot.
    assign w_rot = NUM_REQ'({req, req} >> ptr);

    always_comb begin
        w_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) w_idx = SEL_W'(i);
        end
    end

    assign pick = w_idx + ptr;
    assign any  = |req;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter owning the mux8way select; bounded tenure per owner.
// Optional MUX8_ARB_LOCK_EN adds a lock input that suppresses timeout preemption.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
)(
    input  logic             clk,
    input  logic             reset,
    mux8_rr_arbiter_if.slave bus
);

    localparam int HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t         r_state;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   r_sel;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_busy;
    logic [HOLD_W-1:0]  r_hold_cnt;

    logic [SEL_W-1:0]   w_pick;
    logic               w_any;
    logic               w_owner_req;
    logic               w_others;
    logic               w_timeout;
    logic               w_preempt;

    rr_pick8 u_pick (
        .req  (bus.req),
        .ptr  (r_ptr),
        .pick (w_pick),
        .any  (w_any)
    );

    assign w_owner_req = bus.req[r_sel];
    assign w_others    = |(bus.req & ~onehot8(r_sel));
    assign w_timeout   = (r_hold_cnt == HOLD_LAST);
`ifdef MUX8_ARB_LOCK_EN
    assign w_preempt   = w_timeout && w_others && !bus.lock;
`else
    assign w_preempt   = w_timeout && w_others;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_sel      <= '0;
            r_grant    <= '0;
            r_busy     <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                // IDLE and RELEASE arbitrate identically; RELEASE has just moved ptr.
                IDLE, RELEASE: begin
                    if (w_any) begin
                        r_state    <= GRANT;
                        r_grant    <= onehot8(w_pick);
                        r_sel      <= w_pick;
                        r_busy     <= 1'b1;
                        r_hold_cnt <= '0;
                    end else begin
                        r_state    <= IDLE;
                    end
                end
                GRANT: begin
                    if (!w_owner_req || w_preempt) begin
                        r_state <= RELEASE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= r_sel + SEL_W'(1);
                    end else if (!w_timeout) begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant     = r_grant;
    assign bus.sel       = r_sel;
    assign bus.busy      = r_busy;
    assign bus.dbg_state = r_state;

    a_grant_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(r_grant))
        else $error("grant is not zero/one-hot");
    a_busy_match: assert property (@(posedge clk) disable iff (reset) r_busy == (|r_grant))
        else $error("busy disagrees with grant");
    a_sel_match: assert property (@(posedge clk) disable iff (reset) r_busy |-> r_grant[r_sel])
        else $error("grant bit at sel is clear while busy");

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: directed scenarios plus randomized requests
// checked against a tenure-based reference model. Exercises lock when MUX8_ARB_LOCK_EN is set.
module tb_mux8_rr_arbiter;

    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    mux8_rr_arbiter_if bus_if ();

    mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Expected {grant, sel, busy} after each clock edge.
    logic [11:0] exp_q[$];

    // Reference model: owner index (-1 = none), cycles owned so far, round-robin start.
    int m_owner  = -1;
    int m_tenure = 0;
    int m_ptr    = 0;
    int m_sel    = 0;

    function automatic int rr_pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_tenure = 0;
        m_ptr    = 0;
        m_sel    = 0;
    endtask

    task automatic model_edge(input logic [7:0] r, input bit l);
        logic [7:0] others;
        int p;
        if (m_owner >= 0) begin
            others = r;
            others[m_owner] = 1'b0;
            if (!r[m_owner] || (m_tenure >= MAX_HOLD && others != 8'd0 && !l)) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end else begin
                m_tenure++;
            end
        end else begin
            p = rr_pick(r, m_ptr);
            if (p >= 0) begin
                m_owner  = p;
                m_sel    = p;
                m_tenure = 1;
            end
        end
    endtask

    function automatic logic [11:0] model_out();
        logic [7:0] g;
        g = 8'd0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return {g, 3'(m_sel), (m_owner >= 0)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs; the expected outputs after the edge go to the scoreboard.
    task automatic step(input logic [7:0] r, input bit l);
        bus_if.req = r;
`ifdef MUX8_ARB_LOCK_EN
        bus_if.lock = l;
`endif
        model_edge(r, l);
        @(posedge clk);
        exp_q.push_back(model_out());
        #1;
    endtask

    task automatic hold(input logic [7:0] r, input bit l, input int n);
        for (int i = 0; i < n; i++) step(r, l);
    endtask

    // Monitor: compare DUT outputs at the falling edge against the oldest expectation.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({bus_if.grant, bus_if.sel, bus_if.busy} !== e) begin
                    n_fail++;
                    $display("FAIL out @%0t: got grant=%h sel=%0d busy=%b, expected grant=%h sel=%0d busy=%b",
                             $time, bus_if.grant, bus_if.sel, bus_if.busy, e[11:4], e[3:1], e[0]);
                end
            end
        end
    end

    initial begin
        logic [7:0] r;
        bit l;

        bus_if.req = 8'd0;
`ifdef MUX8_ARB_LOCK_EN
        bus_if.lock = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_grant", 32'(bus_if.grant), 32'h0);
        check("reset_sel",   32'(bus_if.sel),   32'h0);
        check("reset_busy",  32'(bus_if.busy),  32'h0);
        check("reset_state", 32'(bus_if.dbg_state), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Two requesters at both ends of the ring; ptr wraps 7 -> 0.
        hold(8'h81, 1'b0, 3);
        hold(8'h80, 1'b0, 3);
        hold(8'h00, 1'b0, 3);
        // Single requester, drop, then ptr=3 must favour index 3 over 0.
        hold(8'h04, 1'b0, 3);
        hold(8'h00, 1'b0, 2);
        hold(8'h09, 1'b0, 3);
        hold(8'h00, 1'b0, 3);
        // Two persistent requesters: tenure-bounded alternation.
        hold(8'h28, 1'b0, 25);
        hold(8'h00, 1'b0, 3);
        // Lone owner is never preempted.
        hold(8'h40, 1'b0, 20);
        hold(8'h00, 1'b0, 3);
`ifdef MUX8_ARB_LOCK_EN
        hold(8'h06, 1'b1, 12);
        hold(8'h06, 1'b0, 8);
        hold(8'h00, 1'b0, 3);
`endif

        // Asynchronous reset in the middle of a grant.
        hold(8'h10, 1'b0, 3);
        @(negedge clk);
        #1;
        reset = 1'b1;
        bus_if.req = 8'h00;
        #1;
        check("async_grant", 32'(bus_if.grant), 32'h0);
        check("async_sel",   32'(bus_if.sel),   32'h0);
        check("async_busy",  32'(bus_if.busy),  32'h0);
        model_reset();
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        hold(8'h30, 1'b0, 3);
        hold(8'h00, 1'b0, 2);

        // Randomized persistent requests, with occasional global drops.
        r = 8'd0;
        l = 1'b0;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            if ($urandom_range(0, 40) == 0) r = 8'd0;
`ifdef MUX8_ARB_LOCK_EN
            l = ($urandom_range(0, 3) == 0);
`endif
            step(r, l);
        end
        hold(8'h00, 1'b0, 3);

        repeat (2) @(negedge clk);
        #1;
        check("scoreboard_drain", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
